// File: rtl/final_soc_done_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : final_soc_done_pkg
//  Purpose  : Shared register map, bit positions and FSM state type for the
//             accelerator START/DONE sequencer.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package final_soc_done_pkg;

   // Register addresses
   localparam logic [1:0] REG_CTRL     = 2'd0;
   localparam logic [1:0] REG_STATUS   = 2'd1;
   localparam logic [1:0] REG_IRQ_MASK = 2'd2;
   localparam logic [1:0] REG_TIMEOUT  = 2'd3;

   // CONTROL write bits
   localparam int CTRL_START = 0;
   localparam int CTRL_ABORT = 1;

   // STATUS / IRQ_MASK bits
   localparam int ST_DONE = 0;
   localparam int ST_TMO  = 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      WAIT  = 2'd2
   } state_e;

endpackage : final_soc_done_pkg
`default_nettype wire

// File: rtl/final_soc_sync_edge.sv
`default_nettype none
// ============================================================================
//  Module   : final_soc_sync_edge
//  Purpose  : Synchronises the asynchronous DONE level into clk and flags its
//             rising edge for one cycle.
//  Ports    : clk     in  system clock
//             rst     in  asynchronous active-high reset
//             done_i  in  DONE level, asynchronous to clk
//             rise_o  out one-cycle pulse on a synchronised rising edge
//  Revision : 1.0  initial release
// ============================================================================
module final_soc_sync_edge #(
   parameter int SYNC_STAGES = 2   // must be at least 2
) (
   input  logic clk,
   input  logic rst,
   input  logic done_i,
   output logic rise_o
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   hist_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '0;
         hist_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], done_i};
         hist_q <= sync_q[SYNC_STAGES-1];
      end
   end

   // Edge is judged only on the last synchronised stage and its history flop,
   // so a level that was already high produces no pulse.
   assign rise_o = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule : final_soc_sync_edge
`default_nettype wire

// File: rtl/final_soc_done_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : final_soc_done_ctrl
//  Purpose  : Avalon-MM slave that launches the game-logic accelerator with a
//             one-cycle start pulse, waits for DONE or a timeout, latches the
//             outcome in sticky flags and raises a maskable interrupt.
//  Ports    : clk        in  system clock
//             reset      in  asynchronous active-high reset
//             address    in  register select (CTRL/STATUS/IRQ_MASK/TIMEOUT)
//             chipselect in  slave select
//             write_n    in  active-low write strobe
//             writedata  in  write data
//             readdata   out registered read data (1-cycle latency)
//             done_in    in  accelerator DONE level (asynchronous)
//             start_out  out one-cycle start pulse
//             irq        out interrupt to CPU
//  Revision : 1.0  initial release
// ============================================================================
module final_soc_done_ctrl
   import final_soc_done_pkg::*;
#(
   parameter int                   SYNC_STAGES = 2,
   parameter int                   TIMEOUT_W   = 32,
   parameter logic [TIMEOUT_W-1:0] TIMEOUT_RST = TIMEOUT_W'(50000)
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  address,
   input  logic        chipselect,
   input  logic        write_n,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   input  logic        done_in,
   output logic        start_out,
   output logic        irq
);

   localparam logic [TIMEOUT_W-1:0] CNT_ONE = TIMEOUT_W'(1);

   // ------------------------------------------------------------------
   // Bus decode
   // ------------------------------------------------------------------
   logic w_wr_en;
   logic w_start_req;
   logic w_abort_req;
   logic w_unused_wdata;

   assign w_wr_en     = chipselect & ~write_n;
   assign w_start_req = w_wr_en && (address == REG_CTRL) && writedata[CTRL_START];
   assign w_abort_req = w_wr_en && (address == REG_CTRL) && writedata[CTRL_ABORT];
   assign w_unused_wdata = &{1'b0, writedata};

   // ------------------------------------------------------------------
   // DONE synchroniser and edge detector
   // ------------------------------------------------------------------
   logic w_done_rise;

   final_soc_sync_edge #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync_edge (
      .clk    (clk),
      .rst    (reset),
      .done_i (done_in),
      .rise_o (w_done_rise)
   );

   // ------------------------------------------------------------------
   // Sequencer FSM
   // ------------------------------------------------------------------
   state_e                 state_q, state_d;
   logic [TIMEOUT_W-1:0]   cnt_q, cnt_d;
   logic [TIMEOUT_W-1:0]   timeout_q;
   logic                   w_set_done;
   logic                   w_set_tmo;
   logic                   w_busy;

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state logic. A counter loaded with 0 is never decremented, which
   // makes a zero TIMEOUT an unbounded wait without consulting the TIMEOUT
   // register again (later writes must not disturb a running wait).
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      w_set_done = 1'b0;
      w_set_tmo  = 1'b0;
      case (state_q)
         IDLE: begin
            if (w_start_req) begin
               state_d = START;
               cnt_d   = timeout_q;
            end
         end
         START: begin
            state_d = WAIT;
         end
         WAIT: begin
            if (w_abort_req) begin
               state_d = IDLE;
            end else if (w_done_rise) begin
               w_set_done = 1'b1;
               state_d    = IDLE;
            end else if (cnt_q == CNT_ONE) begin
               w_set_tmo = 1'b1;
               state_d   = IDLE;
            end else if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Output logic
   always_comb begin
      start_out = (state_q == START);
      w_busy    = (state_q != IDLE);
   end

   // ------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------
   logic [1:0]  flags_q, flags_d;
   logic [1:0]  mask_q;
   logic [1:0]  w_flag_set;
   logic [1:0]  w_flag_clr;
   logic [31:0] readdata_q, readdata_d;

   always_comb begin
      w_flag_set         = '0;
      w_flag_set[ST_DONE] = w_set_done;
      w_flag_set[ST_TMO]  = w_set_tmo;
      w_flag_clr = (w_wr_en && (address == REG_STATUS)) ? writedata[1:0] : 2'b00;
      // A flag set in the same cycle as its W1C survives.
      flags_d = (flags_q & ~w_flag_clr) | w_flag_set;
   end

   // Read mux sampled every cycle regardless of chipselect.
   always_comb begin
      readdata_d = '0;
      case (address)
         REG_CTRL:     readdata_d[0]           = w_busy;
         REG_STATUS:   readdata_d[1:0]         = flags_q;
         REG_IRQ_MASK: readdata_d[1:0]         = mask_q;
         REG_TIMEOUT:  readdata_d[TIMEOUT_W-1:0] = timeout_q;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         flags_q    <= '0;
         mask_q     <= '0;
         timeout_q  <= TIMEOUT_RST;
         readdata_q <= '0;
      end else begin
         flags_q    <= flags_d;
         readdata_q <= readdata_d;
         if (w_wr_en && (address == REG_IRQ_MASK)) begin
            mask_q <= writedata[1:0];
         end
         if (w_wr_en && (address == REG_TIMEOUT)) begin
            timeout_q <= writedata[TIMEOUT_W-1:0];
         end
      end
   end

   assign readdata = readdata_q;
   // Driven purely from flops so there is no input-to-irq combinational path.
   assign irq      = |(flags_q & mask_q);

endmodule : final_soc_done_ctrl
`default_nettype wire

// File: tb/tb_final_soc_done_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_final_soc_done_ctrl
//  Purpose  : Self-checking bench for final_soc_done_ctrl. A timestamp-based
//             reference model predicts flags, busy, start pulse and read data;
//             read responses go through a scoreboard queue.
//  Revision : 1.0  initial release
// ============================================================================
module tb_final_soc_done_ctrl;

   localparam int          S    = 2;
   localparam logic [31:0] TRST = 32'd50000;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic        done_in;
   logic        start_out;
   logic        irq;
   logic        rd;

   always #5 clk = ~clk;

   final_soc_done_ctrl #(
      .SYNC_STAGES (S),
      .TIMEOUT_W   (32),
      .TIMEOUT_RST (TRST)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .done_in    (done_in),
      .start_out  (start_out),
      .irq        (irq)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual %0d required %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // ------------------------------------------------------------------
   // Reference model: a run is described by its start edge and loaded
   // timeout; the outcome is decided by comparing edge numbers.
   // ------------------------------------------------------------------
   int          n;          // index of the current clock edge
   bit          m_busy;
   int          m_s;        // edge at which the start write was accepted
   logic [31:0] m_T;        // timeout captured at start
   logic [31:0] m_tmo;
   logic [1:0]  m_flags;
   logic [1:0]  m_mask;
   logic [S:0]  dh;         // dh[i] = done_in sampled i+1 edges ago
   bit          m_start;
   logic [31:0] q_rd[$];

   logic        e_rise, e_wr, e_sw, e_aw;
   logic [1:0]  e_set, e_w1c;
   logic [31:0] e_rexp;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_busy  = 1'b0;
         m_s     = 0;
         m_T     = '0;
         m_tmo   = TRST;
         m_flags = '0;
         m_mask  = '0;
         dh      = '0;
         m_start = 1'b0;
         q_rd.delete();
      end else begin
         n      = n + 1;
         e_wr   = chipselect & ~write_n;
         e_sw   = e_wr && address == 2'd0 && writedata[0];
         e_aw   = e_wr && address == 2'd0 && writedata[1];
         e_rise = dh[S-1] & ~dh[S];
         e_set  = 2'b00;
         e_w1c  = (e_wr && address == 2'd1) ? writedata[1:0] : 2'b00;

         if (rd) begin
            case (address)
               2'd0:    e_rexp = {31'd0, m_busy};
               2'd1:    e_rexp = {30'd0, m_flags};
               2'd2:    e_rexp = {30'd0, m_mask};
               default: e_rexp = m_tmo;
            endcase
            q_rd.push_back(e_rexp);
         end

         if (!m_busy) begin
            if (e_sw) begin
               m_busy = 1'b1;
               m_s    = n;
               m_T    = m_tmo;
            end
         end else if (n >= m_s + 2) begin
            if (e_aw) begin
               m_busy = 1'b0;
            end else if (e_rise) begin
               e_set[0] = 1'b1;
               m_busy   = 1'b0;
            end else if (m_T != 0 && n == m_s + 1 + int'(m_T)) begin
               e_set[1] = 1'b1;
               m_busy   = 1'b0;
            end
         end

         m_flags = (m_flags & ~e_w1c) | e_set;
         if (e_wr && address == 2'd2) m_mask = writedata[1:0];
         if (e_wr && address == 2'd3) m_tmo  = writedata;
         dh      = {dh[S-1:0], done_in};
         m_start = m_busy && (m_s == n);
      end
   end

   // ------------------------------------------------------------------
   // Monitor
   // ------------------------------------------------------------------
   always @(negedge clk) begin
      if (reset) begin
         chk("reset_start_out", {31'd0, start_out}, 32'd0);
         chk("reset_irq",       {31'd0, irq},       32'd0);
         chk("reset_readdata",  readdata,           32'd0);
      end else begin
         chk("start_out", {31'd0, start_out}, {31'd0, m_start});
         chk("irq",       {31'd0, irq},       {31'd0, |(m_flags & m_mask)});
         if (q_rd.size() > 0) chk("readdata", readdata, q_rd.pop_front());
      end
   end

   // ------------------------------------------------------------------
   // Stimulus (tasks start and end 2 time units after a rising edge)
   // ------------------------------------------------------------------
   task automatic bus_idle();
      chipselect = 1'b0;
      write_n    = 1'b1;
      address    = 2'd0;
      writedata  = '0;
      rd         = 1'b0;
   endtask

   task automatic step(input int k);
      repeat (k) @(posedge clk);
      #2;
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      chipselect = 1'b1;
      write_n    = 1'b0;
      address    = a;
      writedata  = d;
      rd         = 1'b0;
      step(1);
      bus_idle();
   endtask

   task automatic rdreg(input logic [1:0] a);
      chipselect = 1'b1;
      write_n    = 1'b1;
      address    = a;
      rd         = 1'b1;
      step(1);
      bus_idle();
   endtask

   initial begin
      n       = 0;
      reset   = 1'b1;
      done_in = 1'b0;
      bus_idle();
      step(3);
      reset = 1'b0;
      rdreg(2'd3);

      // Normal completion
      wr(2'd3, 32'd100); wr(2'd2, 32'd1); wr(2'd0, 32'd1);
      step(9); done_in = 1'b1; step(2); done_in = 1'b0; step(6);
      rdreg(2'd1); rdreg(2'd0); wr(2'd1, 32'd1); rdreg(2'd1);

      // Timeout
      wr(2'd3, 32'd5); wr(2'd2, 32'd2); wr(2'd0, 32'd1);
      step(10); rdreg(2'd1); wr(2'd1, 32'd3);

      // DONE edge lands in the expiry cycle
      wr(2'd3, S + 1); wr(2'd2, 32'd3); wr(2'd0, 32'd1);
      step(1); done_in = 1'b1; step(3); done_in = 1'b0; step(5);
      rdreg(2'd1); wr(2'd1, 32'd3);

      // Abort mid-wait
      wr(2'd3, 32'd100); wr(2'd0, 32'd1); step(3); wr(2'd0, 32'd2);
      rdreg(2'd0); rdreg(2'd1);

      // Back-to-back start, abort during START, start+abort while busy/idle
      wr(2'd0, 32'd1); wr(2'd0, 32'd3); step(2); wr(2'd0, 32'd3); rdreg(2'd0);
      wr(2'd0, 32'd3); step(3); wr(2'd0, 32'd2); rdreg(2'd0);

      // DONE already high before start
      done_in = 1'b1; step(4);
      wr(2'd3, 32'd4); wr(2'd0, 32'd1); step(8); rdreg(2'd1);
      done_in = 1'b0; step(4); wr(2'd1, 32'd3);

      // TIMEOUT rewritten while busy, then TIMEOUT=1
      wr(2'd3, 32'd6); wr(2'd0, 32'd1); step(2); wr(2'd3, 32'd1); step(8);
      rdreg(2'd3); rdreg(2'd1); wr(2'd0, 32'd1); step(4); rdreg(2'd1); wr(2'd1, 32'd3);

      // Unbounded wait
      wr(2'd3, 32'd0); wr(2'd0, 32'd1); step(20); rdreg(2'd0); wr(2'd0, 32'd2);

      // Reset mid-wait
      wr(2'd3, 32'd100); wr(2'd2, 32'd3); wr(2'd0, 32'd1); step(4);
      reset = 1'b1; step(2); reset = 1'b0;
      rdreg(2'd0); rdreg(2'd1); rdreg(2'd3); rdreg(2'd2);

      // Randomised traffic
      for (int i = 0; i < 1500; i++) begin
         case ($urandom_range(0, 9))
            0:       wr(2'd0, $urandom_range(0, 3));
            1:       wr(2'd1, $urandom_range(0, 3));
            2:       wr(2'd2, $urandom_range(0, 3));
            3:       wr(2'd3, $urandom_range(0, 12));
            4, 5:    rdreg(2'($urandom_range(0, 3)));
            6:       begin done_in = ~done_in; step(1); end
            default: step(1);
         endcase
      end

      done_in = 1'b0;
      step(5);
      chk("scoreboard_drained", q_rd.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_final_soc_done_ctrl
`default_nettype wire
